// File: rtl/i2s_serializer.sv
// i2s_serializer
// Serialises stereo PCM sample pairs into an I2S stream (bck_out / lrck / sdata).
// Runs entirely on clkin. The bit clock arrives as bck_in, a divided clock that is
// generated synchronously on clkin. Only its falling edges advance the serializer.
// A one-pair holding buffer behind a valid/ready handshake feeds the active registers.
// The active registers reload at every frame start. If the buffer is empty at that
// point, the frame is played as silence and the underrun output pulses.
// Optional feature macro: I2S_SERIALIZER_UNDERRUN_COUNT_EN adds the saturating
// underrun_count output and its CNT_WIDTH parameter.
module i2s_serializer #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_WIDTH   = 32
`ifdef I2S_SERIALIZER_UNDERRUN_COUNT_EN
    ,
    parameter int CNT_WIDTH    = 16
`endif
) (
    input  logic                    clkin,
    input  logic                    reset,
    input  logic                    bck_in,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    input  logic [SAMPLE_WIDTH-1:0] sample_left,
    input  logic [SAMPLE_WIDTH-1:0] sample_right,
    output logic                    bck_out,
    output logic                    lrck,
    output logic                    sdata,
    output logic                    underrun
`ifdef I2S_SERIALIZER_UNDERRUN_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0]    underrun_count
`endif
);

    localparam int FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int BW         = $clog2(FRAME_BITS);
    localparam int PW         = $clog2(SLOT_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] SLOT_W   = BW'(SLOT_WIDTH);

    logic                    bck_d_q;
    logic                    bck_out_q;
    logic [BW-1:0]           bit_cnt_q,   bit_cnt_d;
    logic                    lrck_q,      lrck_d;
    logic                    sdata_q,     sdata_d;
    logic                    underrun_q,  underrun_d;
    logic                    hold_full_q, hold_full_d;
    logic [SAMPLE_WIDTH-1:0] hold_l_q,    hold_l_d;
    logic [SAMPLE_WIDTH-1:0] hold_r_q,    hold_r_d;
    logic [SAMPLE_WIDTH-1:0] act_l_q,     act_l_d;
    logic [SAMPLE_WIDTH-1:0] act_r_q,     act_r_d;

    logic                    fall;
    logic [BW-1:0]           k;
    logic                    in_right;
    logic [PW-1:0]           p;
    logic                    frame_start;
    logic                    accept;
    logic [SLOT_WIDTH-1:0]   slot_l;
    logic [SLOT_WIDTH-1:0]   slot_r;

    // Edge detection and slot position of the bit being launched on this fall.
    assign fall        = bck_d_q & ~bck_in;
    assign k           = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + BW'(1);
    assign in_right    = (k >= SLOT_W);
    assign p           = in_right ? PW'(k - SLOT_W) : PW'(k);
    assign frame_start = fall & (k == '0);
    assign accept      = sample_valid & ~hold_full_q;

    // Lay each active sample out as a slot image indexed by slot position p.
    // Position 0 is the I2S one-bit delay. Positions 1..SAMPLE_WIDTH carry the
    // sample MSB first. The remaining positions are zero padding.
    generate
        for (genvar gi = 0; gi < SLOT_WIDTH; gi++) begin : g_slot
            if (gi >= 1 && gi <= SAMPLE_WIDTH) begin : g_data
                assign slot_l[gi] = act_l_q[SAMPLE_WIDTH-gi];
                assign slot_r[gi] = act_r_q[SAMPLE_WIDTH-gi];
            end else begin : g_pad
                assign slot_l[gi] = 1'b0;
                assign slot_r[gi] = 1'b0;
            end
        end
    endgenerate

    // Next-state logic: bit position and serial outputs, handshake buffer, frame reload.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        lrck_d      = lrck_q;
        sdata_d     = sdata_q;
        underrun_d  = 1'b0;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        act_l_d     = act_l_q;
        act_r_d     = act_r_q;

        if (fall) begin
            bit_cnt_d = k;
            lrck_d    = in_right;
            sdata_d   = in_right ? slot_r[p] : slot_l[p];
        end

        if (accept) begin
            hold_l_d    = sample_left;
            hold_r_d    = sample_right;
            hold_full_d = 1'b1;
        end

        // The reload happens on the p==0 fall, so the p==1 bit already uses the new pair.
        // accept and a full buffer are mutually exclusive. A pair accepted on the frame
        // start therefore stays in hold for the next frame.
        if (frame_start) begin
            if (hold_full_q) begin
                act_l_d     = hold_l_q;
                act_r_d     = hold_r_q;
                hold_full_d = 1'b0;
            end else begin
                act_l_d    = '0;
                act_r_d    = '0;
                underrun_d = 1'b1;
            end
        end
    end

    // State registers. bck_out is a plain one-cycle delay of bck_in, so it lines up
    // with lrck and sdata.
    always_ff @(posedge clkin) begin
        if (reset) begin
            bck_d_q     <= 1'b0;
            bck_out_q   <= 1'b0;
            bit_cnt_q   <= LAST_BIT;
            lrck_q      <= 1'b1;
            sdata_q     <= 1'b0;
            underrun_q  <= 1'b0;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            act_l_q     <= '0;
            act_r_q     <= '0;
        end else begin
            bck_d_q     <= bck_in;
            bck_out_q   <= bck_in;
            bit_cnt_q   <= bit_cnt_d;
            lrck_q      <= lrck_d;
            sdata_q     <= sdata_d;
            underrun_q  <= underrun_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            act_l_q     <= act_l_d;
            act_r_q     <= act_r_d;
        end
    end

    assign sample_ready = ~hold_full_q;
    assign bck_out      = bck_out_q;
    assign lrck         = lrck_q;
    assign sdata        = sdata_q;
    assign underrun     = underrun_q;

`ifdef I2S_SERIALIZER_UNDERRUN_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Saturating count of underruns. It steps on the same edge that raises underrun.
    always_comb begin
        cnt_d = cnt_q;
        if (underrun_d && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // Counter register. Only reset clears it.
    always_ff @(posedge clkin) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign underrun_count = cnt_q;
`endif

endmodule

// File: tb/tb_i2s_serializer.sv
// tb_i2s_serializer
// Drives sample pairs through the handshake and a divide-by-4 bit clock.
// A frame monitor rebuilds each left/right slot from sdata and compares it with the
// scoreboard entry that was queued when the pair was accepted. A frame with no
// eligible entry must be silent and must raise underrun.
`timescale 1ns/1ps
module tb_i2s_serializer;

    localparam int SW   = 24;
    localparam int SLOT = 32;

    logic          clkin        = 1'b0;
    logic          reset        = 1'b1;
    logic          bck_in       = 1'b0;
    logic          sample_valid = 1'b0;
    logic [SW-1:0] sample_left  = '0;
    logic [SW-1:0] sample_right = '0;
    logic          sample_ready;
    logic          bck_out;
    logic          lrck;
    logic          sdata;
    logic          underrun;
`ifdef I2S_SERIALIZER_UNDERRUN_COUNT_EN
    logic [1:0]    underrun_count;
`endif

    i2s_serializer #(
        .SAMPLE_WIDTH (SW),
        .SLOT_WIDTH   (SLOT)
`ifdef I2S_SERIALIZER_UNDERRUN_COUNT_EN
        ,
        .CNT_WIDTH    (2)
`endif
    ) dut (
        .clkin        (clkin),
        .reset        (reset),
        .bck_in       (bck_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .bck_out      (bck_out),
        .lrck         (lrck),
        .sdata        (sdata),
        .underrun     (underrun)
`ifdef I2S_SERIALIZER_UNDERRUN_COUNT_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    always #5 clkin = ~clkin;

    typedef struct {
        logic [SW-1:0] left;
        logic [SW-1:0] right;
        logic [31:0]   exp_l;
        logic [31:0]   exp_r;
    } vec_t;

    typedef struct {
        int          acc_cyc;
        logic [31:0] exp_l;
        logic [31:0] exp_r;
    } sb_t;

    vec_t vecs [5];
    sb_t  sb_q [$];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic bck_samp = 1'b0;
    logic rst_samp = 1'b1;
    bit   bck_run  = 1'b0;
    bit   bck_clr  = 1'b1;
    logic [1:0] div = 2'd0;

    // Monitor state
    int          mon_pos        = 63;
    logic        mon_prev       = 1'b0;
    logic        mon_fall       = 1'b0;
    bit          frame_valid    = 1'b0;
    int          aux_err        = 0;
    logic [31:0] slot_l_m       = '0;
    logic [31:0] slot_r_m       = '0;
    logic [31:0] cur_l          = '0;
    logic [31:0] cur_r          = '0;
    logic        cur_under      = 1'b1;
    int          frames_started = 0;
    int          frames_done    = 0;
    int          underruns_seen = 0;
    logic        prev_lrck      = 1'b1;
    logic        prev_sdata     = 1'b0;
    sb_t         mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    task automatic tick();
        @(negedge clkin);
        #1;
    endtask

    // Capture what the DUT saw at each active edge.
    always @(posedge clkin) begin
        bck_samp <= bck_in;
        rst_samp <= reset;
        cyc      <= cyc + 1;
    end

    // Divide-by-4 bit clock, changed just after the clkin edge. It can be frozen or cleared.
    initial forever begin
        @(posedge clkin);
        #1;
        if (bck_clr) div = 2'd0;
        else if (bck_run) div = div + 2'd1;
        bck_in = div[1];
    end

    // Frame monitor and scoreboard consumer.
    initial forever begin
        @(negedge clkin);
        if (rst_samp) begin
            mon_pos     = 63;
            mon_prev    = 1'b0;
            frame_valid = 1'b0;
            aux_err     = 0;
        end else begin
            mon_fall = mon_prev & ~bck_samp;
            mon_prev = bck_samp;
            if (bck_out !== bck_samp) aux_err++;
            if (underrun === 1'b1) underruns_seen++;
            if (mon_fall) begin
                mon_pos = (mon_pos == 63) ? 0 : mon_pos + 1;
                if (lrck !== (mon_pos >= SLOT)) aux_err++;
                if (mon_pos == 0) begin
                    if (sb_q.size() > 0 && sb_q[0].acc_cyc < cyc) begin
                        mon_e     = sb_q.pop_front();
                        cur_l     = mon_e.exp_l;
                        cur_r     = mon_e.exp_r;
                        cur_under = 1'b0;
                        check("frame_start_ready", sample_ready, 1'b1);
                    end else begin
                        cur_l     = '0;
                        cur_r     = '0;
                        cur_under = 1'b1;
                    end
                    check("frame_start_underrun", underrun, cur_under);
                    frame_valid = 1'b1;
                    aux_err     = 0;
                    frames_started++;
                end else if (underrun !== 1'b0) begin
                    aux_err++;
                end
                if (mon_pos < SLOT) slot_l_m = {slot_l_m[30:0], sdata};
                else                slot_r_m = {slot_r_m[30:0], sdata};
                if (mon_pos == 63 && frame_valid) begin
                    $display("[TB] frame %0d slotL=%h slotR=%h underrun=%0b", frames_done, slot_l_m, slot_r_m, cur_under);
                    check("frame_data", {slot_l_m, slot_r_m}, {cur_l, cur_r});
                    check("frame_aux_errors", 64'(aux_err), 64'd0);
                    frames_done++;
                end
            end else begin
                if (underrun !== 1'b0 || lrck !== prev_lrck || sdata !== prev_sdata) aux_err++;
            end
        end
        prev_lrck  = lrck;
        prev_sdata = sdata;
    end

    task automatic wait_starts_to(input int target);
        int budget;
        budget = (target - frames_started) * 300 + 50;
        while (frames_started < target && budget > 0) begin tick(); budget--; end
        if (frames_started < target) timeout("wait_frame_start");
    endtask

    task automatic wait_done_to(input int target);
        int budget;
        budget = (target - frames_done) * 300 + 300;
        while (frames_done < target && budget > 0) begin tick(); budget--; end
        if (frames_done < target) timeout("wait_frame_done");
    endtask

    task automatic wait_pos(input int pos);
        int budget;
        budget = 600;
        while (!(mon_pos == pos && frame_valid) && budget > 0) begin tick(); budget--; end
        if (!(mon_pos == pos && frame_valid)) timeout("wait_pos");
    endtask

    // Present a pair, wait for acceptance and queue its expected slot images.
    task automatic send_pair(input int idx, input bit keep_valid);
        int budget;
        sample_left  = vecs[idx].left;
        sample_right = vecs[idx].right;
        sample_valid = 1'b1;
        budget = 600;
        while (!sample_ready && budget > 0) begin tick(); budget--; end
        if (!sample_ready) begin
            timeout("send_pair_ready");
            sample_valid = 1'b0;
            return;
        end
        @(posedge clkin);
        #1;
        sb_q.push_back('{cyc, vecs[idx].exp_l, vecs[idx].exp_r});
        $display("[TB] accepted pair %0d L=%h R=%h at cycle %0d", idx, vecs[idx].left, vecs[idx].right, cyc);
        check("ready_drop", sample_ready, 1'b0);
        if (!keep_valid) sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bck_clr      = 1'b1;
        bck_run      = 1'b0;
        sample_valid = 1'b0;
        sb_q.delete();
        tick();
        check("rst_ready", sample_ready, 1'b1);
        check("rst_bck_out", bck_out, 1'b0);
        check("rst_lrck", lrck, 1'b1);
        check("rst_sdata", sdata, 1'b0);
        check("rst_underrun", underrun, 1'b0);
`ifdef I2S_SERIALIZER_UNDERRUN_COUNT_EN
        check("rst_count", underrun_count, 2'd0);
`endif
        tick();
        reset   = 1'b0;
        bck_clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int u0;
        logic [4:0] snap;

        // Expected slot images are listed with p=0 as the MSB.
        vecs[0] = '{24'hA5A5A5, 24'h5A5A5A, 32'h52D2D280, 32'h2D2D2D00};
        vecs[1] = '{24'h800001, 24'h7FFFFF, 32'h40000080, 32'h3FFFFF80};
        vecs[2] = '{24'hFFFFFF, 24'h000001, 32'h7FFFFF80, 32'h00000080};
        vecs[3] = '{24'h123456, 24'hABCDEF, 32'h091A2B00, 32'h55E6F780};
        vecs[4] = '{24'hC3C3C3, 24'h3C3C3C, 32'h61E1E180, 32'h1E1E1E00};

        tick();
        do_reset();

        // Load the first pair before any fall, then stream the rest with valid held high.
        base = frames_done;
        send_pair(0, 1'b1);
        repeat (10) tick();
        check("ready_hold_while_stuck", sample_ready, 1'b0);
        bck_run = 1'b1;
        for (int i = 1; i < 4; i++) send_pair(i, 1'b1);
        sample_valid = 1'b0;
        wait_done_to(base + 4);

        // No samples: every frame is silent and underruns.
        do_reset();
        u0   = underruns_seen;
        base = frames_started;
        bck_run = 1'b1;
        wait_starts_to(base + 3);
        check("underruns_3_frames", 64'(underruns_seen - u0), 64'd3);
`ifdef I2S_SERIALIZER_UNDERRUN_COUNT_EN
        check("count_after_3", underrun_count, 2'd3);
`endif
        wait_starts_to(base + 5);
        check("underruns_5_frames", 64'(underruns_seen - u0), 64'd5);
`ifdef I2S_SERIALIZER_UNDERRUN_COUNT_EN
        check("count_saturated", underrun_count, 2'd3);
`endif

        // Valid lands on the frame-start edge with hold empty.
        do_reset();
        bck_run = 1'b1;
        begin
            int budget;
            budget = 100;
            while (!(mon_pos == 63 && bck_samp == 1'b1 && bck_in == 1'b0) && budget > 0) begin
                tick();
                budget--;
            end
            if (budget == 0) timeout("pre_frame_start");
        end
        sample_left  = vecs[4].left;
        sample_right = vecs[4].right;
        sample_valid = 1'b1;
        @(posedge clkin);
        #1;
        sb_q.push_back('{cyc, vecs[4].exp_l, vecs[4].exp_r});
        $display("[TB] accepted pair 4 on frame start at cycle %0d", cyc);
        sample_valid = 1'b0;
        check("ready_drop_at_start", sample_ready, 1'b0);
        tick();
        check("start_accept_underrun", underrun, 1'b1);
        base = frames_done;
        wait_starts_to(frames_started + 1);

        // Freeze the bit clock in the middle of the played frame. Everything must hold.
        wait_pos(20);
        bck_run = 1'b0;
        tick();
        tick();
        snap = {lrck, sdata, bck_out, sample_ready, underrun};
        repeat (20) tick();
        check("stuck_hold", {lrck, sdata, bck_out, sample_ready, underrun}, snap);
        check("stuck_no_underrun", underrun, 1'b0);
        bck_run = 1'b1;
        wait_done_to(base + 2);

        // Reset mid-frame with hold full: held and active pairs are discarded.
        do_reset();
        send_pair(1, 1'b0);
        bck_run = 1'b1;
        send_pair(2, 1'b0);
        wait_pos(40);
        check("hold_full_before_reset", sample_ready, 1'b0);
        base = frames_done;
        do_reset();
        bck_run = 1'b1;
        wait_done_to(base + 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
